// File: rtl/stream_acc_array.sv
// stream_acc_array
//   Converts LANE parallel stochastic bitstreams into binary values by
//   counting over a window of N = 2**CWID accepted beats.
//   The FSM steps through IDLE, ACC and HOLD. In ACC, a beat is a cycle
//   with enable=1. After the last beat of the window, the per-lane counts
//   are latched into cntOut and held with outValid=1. They stay there until
//   outValid & outReady.
//
//   Build option:
//     STREAM_ACC_BIPOLAR_EN  defined   -> bipolar decode,
//                                         cntOut = 2*ones - N (signed)
//                            undefined -> unipolar decode,
//                                         cntOut = ones (unsigned)
//
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-high reset
//     start     in   request a new conversion window (IDLE, or HOLD+handshake)
//     enable    in   bitSeq carries a valid beat (ACC only)
//     bitSeq    in   [LANE-1:0] one stochastic bit per lane
//     busy      out  high while accumulating (ACC)
//     outValid  out  cntOut holds a completed result (HOLD)
//     outReady  in   consumer accepts the result
//     cntOut    out  [LANE-1:0] x [CWID+1:0] per-lane decoded value
module stream_acc_array #(
  parameter int CWID = 8,
  parameter int LANE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            enable,
  input  logic [LANE-1:0] bitSeq,
  output logic            busy,
  output logic            outValid,
  input  logic            outReady,
  output logic [CWID+1:0] cntOut [LANE-1:0]
);

  localparam int AW = CWID + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [CWID-1:0] win_q;
  logic [AW-1:0]   acc_q [LANE-1:0];
  logic [AW-1:0]   acc_d [LANE-1:0];
  logic [AW-1:0]   cnt_q [LANE-1:0];
  logic            valid_q;
  logic            busy_q;

  // Per-lane value after accepting the current beat. AW bits cover the
  // range 0..N (unipolar) and -N..+N (bipolar), so the count cannot wrap.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < LANE; i++) begin
`ifdef STREAM_ACC_BIPOLAR_EN
      acc_d[i] = bitSeq[i] ? acc_q[i] + AW'(1) : acc_q[i] - AW'(1);
`else
      acc_d[i] = acc_q[i] + AW'(bitSeq[i]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      acc_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '{default: '0};
            win_q   <= '0;
            state_q <= ACC;
            busy_q  <= 1'b1;
          end
        end
        ACC: begin
          if (enable) begin
            acc_q <= acc_d;
            win_q <= win_q + CWID'(1);
            // Counter at all-ones means this beat wraps it: window complete.
            if (win_q == '1) begin
              cnt_q   <= acc_d;
              state_q <= HOLD;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (outReady) begin
            valid_q <= 1'b0;
            // A start on the handshake cycle chains straight into a new window.
            if (start) begin
              acc_q   <= '{default: '0};
              win_q   <= '0;
              state_q <= ACC;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign outValid = valid_q;
  assign cntOut   = cnt_q;

endmodule

// File: doc/stream_acc_array.md
STREAM_ACC_ARRAY -- requirements
Module: stream_acc_array

Interface
REQ-001 SHALL have parameter CWID, default 8: window-counter width; window length N = 2^CWID accepted beats.
REQ-002 SHALL have parameter LANE, default 16: number of independent stochastic bitstream lanes.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request a new conversion window.
REQ-006 SHALL have port enable, input, 1: bitSeq holds a valid beat this cycle.
REQ-007 SHALL have port bitSeq, input, LANE: one stochastic bit per lane.
REQ-008 SHALL have port busy, output, 1: high in ACC state.
REQ-009 SHALL have port outValid, output, 1: cntOut holds a completed result.
REQ-010 SHALL have port outReady, input, 1: consumer accepts the result.
REQ-011 SHALL have port cntOut, output, unpacked array [LANE-1:0] of CWID+2 bits: per-lane decoded binary value.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, HOLD; the reset state is IDLE.
REQ-013 In IDLE with start=1, SHALL clear all lane accumulators and the window counter, then enter ACC next cycle; bitSeq in the start cycle is ignored.
REQ-014 In ACC, each cycle with enable=1 is one beat: each lane accumulator updates per REQ-022/REQ-023 and the window counter increments.
REQ-015 In ACC, a cycle with enable=0 SHALL leave accumulators and window counter unchanged (stall, no timeout).
REQ-016 The beat that wraps the CWID-bit window counter from N-1 to 0 is the last beat; the FSM SHALL enter HOLD the next cycle, latching accumulator values into cntOut with outValid=1.
REQ-017 Latency: last beat at cycle t -> outValid=1 and cntOut valid at cycle t+1.
REQ-018 In HOLD, cntOut and outValid SHALL stay stable until outValid&outReady; on that cycle the FSM SHALL go to IDLE, or directly to ACC with cleared accumulators if start=1 in the same cycle.
REQ-019 start in ACC, or in HOLD without handshake, SHALL be ignored (no restart, no queueing).
REQ-020 outReady outside HOLD SHALL have no effect; enable outside ACC SHALL have no effect.
REQ-021 Accumulators SHALL be CWID+2 bits and never overflow for any input pattern.

Reset
REQ-024 rst=1 SHALL, on the next rising edge, force IDLE, busy=0, outValid=0, cntOut all lanes 0, accumulators 0, window counter 0, regardless of state; rst has priority over start and handshake.
REQ-025 A reset mid-window SHALL discard the partial window; no outValid pulse is produced for it.

Configuration
REQ-026 Macro STREAM_ACC_BIPOLAR_EN selects the decode format.
REQ-022 Without STREAM_ACC_BIPOLAR_EN (unipolar): each beat adds bitSeq[i] to lane i; cntOut[i] = number of ones in window, range 0..N, zero-extended unsigned.
REQ-023 With STREAM_ACC_BIPOLAR_EN (bipolar): each beat adds +1 for bit 1, -1 for bit 0; cntOut[i] = 2*ones - N as two's-complement signed CWID+2 bits, range -N..+N.

Verification (CWID=4, N=16, LANE=4)
REQ-027 Unipolar: start, 16 beats with lane0 all 1, lane1 all 0, lane2 alternating 1/0, lane3 one 1 -> outValid one cycle after beat 16, cntOut={1,8,0,16} (lane3..lane0).
REQ-028 Bipolar build, same stimulus -> cntOut={-14,0,-16,+16}.
REQ-029 Stall: 16 beats interleaved with 10 enable=0 cycles -> same result as REQ-027, outValid 1 cycle after the 16th beat, busy=1 throughout.
REQ-030 Backpressure: outReady=0 for 5 cycles in HOLD with start pulses and bitSeq toggling -> cntOut/outValid stable; outReady=1 with start=1 -> next cycle ACC, accumulators 0, busy=1.
REQ-031 Reset mid-window: rst=1 after beat 7 -> next cycle IDLE, all outputs 0; new start plus 16 beats yields only that window's counts.
REQ-032 start during ACC at beat 9 -> ignored; result after beat 16 matches an uninterrupted window.
